// File: rtl/alu_issue_ctrl.sv
// Issue controller for a 64-bit combinational ALU: decodes one RV64 integer instruction per transaction.
// Optional XOR/XORI decode is enabled by defining ALU_ISSUE_XOR_EN.
module alu_issue_ctrl #(
   parameter int unsigned XLEN = 64,
   parameter int unsigned ILEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [ILEN-1:0] instr,
   input  logic [XLEN-1:0] rs1_val,
   input  logic [XLEN-1:0] rs2_val,
   output logic [XLEN-1:0] alu_a,
   output logic [XLEN-1:0] alu_b,
   output logic [3:0]      alu_ctrl,
   input  logic [XLEN-1:0] alu_result,
   input  logic            alu_zero,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_result,
   output logic            out_taken,
   output logic            out_illegal
);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] F7_ZERO   = 7'b0000000;
   localparam logic [6:0] F7_SUB    = 7'b0100000;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
`ifdef ALU_ISSUE_XOR_EN
   localparam logic [3:0] ALU_XOR = 4'b0011;
`endif

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t state, state_next;

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [6:0]      funct7;
   logic [XLEN-1:0] imm_i;
   logic [XLEN-1:0] imm_s;
   logic            unused_bits;

   logic [3:0]      dec_ctrl;
   logic [XLEN-1:0] dec_b;
   logic            dec_legal;
   logic            dec_branch;
   logic            dec_bne;

   logic            illegal_q;
   logic            branch_q;
   logic            bne_q;
   logic            accept;

   assign opcode      = instr[6:0];
   assign funct3      = instr[14:12];
   assign funct7      = instr[31:25];
   assign imm_i       = {{(XLEN-12){instr[31]}}, instr[31:20]};
   assign imm_s       = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
   // rs1 field is only consumed upstream (register read)
   assign unused_bits = ^instr[19:15];

   assign accept = in_valid && (state == IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = EXEC;
         EXEC:    state_next = RESP;
         RESP:    if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Instruction decode to ALU op, operand B selection and branch flavour
   always_comb begin
      dec_ctrl   = ALU_AND;
      dec_b      = rs2_val;
      dec_legal  = 1'b0;
      dec_branch = 1'b0;
      dec_bne    = 1'b0;
      case (opcode)
         OP_R: begin
            if (funct7 == F7_ZERO) begin
               case (funct3)
                  3'b000: begin dec_ctrl = ALU_ADD; dec_legal = 1'b1; end
                  3'b111: begin dec_ctrl = ALU_AND; dec_legal = 1'b1; end
                  3'b110: begin dec_ctrl = ALU_OR;  dec_legal = 1'b1; end
`ifdef ALU_ISSUE_XOR_EN
                  3'b100: begin dec_ctrl = ALU_XOR; dec_legal = 1'b1; end
`endif
                  default: ;
               endcase
            end else if ((funct7 == F7_SUB) && (funct3 == 3'b000)) begin
               dec_ctrl  = ALU_SUB;
               dec_legal = 1'b1;
            end
         end
         OP_I: begin
            dec_b = imm_i;
            case (funct3)
               3'b000: begin dec_ctrl = ALU_ADD; dec_legal = 1'b1; end
               3'b111: begin dec_ctrl = ALU_AND; dec_legal = 1'b1; end
               3'b110: begin dec_ctrl = ALU_OR;  dec_legal = 1'b1; end
`ifdef ALU_ISSUE_XOR_EN
               3'b100: begin dec_ctrl = ALU_XOR; dec_legal = 1'b1; end
`endif
               default: ;
            endcase
         end
         OP_LOAD: begin
            dec_ctrl  = ALU_ADD;
            dec_b     = imm_i;
            dec_legal = 1'b1;
         end
         OP_STORE: begin
            dec_ctrl  = ALU_ADD;
            dec_b     = imm_s;
            dec_legal = 1'b1;
         end
         OP_BRANCH: begin
            if (funct3[2:1] == 2'b00) begin
               dec_ctrl   = ALU_SUB;
               dec_legal  = 1'b1;
               dec_branch = 1'b1;
               dec_bne    = funct3[0];
            end
         end
         default: ;
      endcase
   end

   // Operand launch on accept, result capture at end of EXEC, handshake flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_ready    <= 1'b1;
         out_valid   <= 1'b0;
         alu_a       <= '0;
         alu_b       <= '0;
         alu_ctrl    <= ALU_AND;
         out_result  <= '0;
         out_taken   <= 1'b0;
         out_illegal <= 1'b0;
         illegal_q   <= 1'b0;
         branch_q    <= 1'b0;
         bne_q       <= 1'b0;
      end else begin
         in_ready <= (state_next == IDLE);
         if (accept) begin
            alu_a     <= dec_legal ? rs1_val  : '0;
            alu_b     <= dec_legal ? dec_b    : '0;
            alu_ctrl  <= dec_legal ? dec_ctrl : ALU_AND;
            illegal_q <= ~dec_legal;
            branch_q  <= dec_legal & dec_branch;
            bne_q     <= dec_bne;
         end
         if (state == EXEC) begin
            out_valid   <= 1'b1;
            out_result  <= illegal_q ? '0 : alu_result;
            out_taken   <= branch_q & (alu_zero ^ bne_q);
            out_illegal <= illegal_q;
         end else if ((state == RESP) && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed self-checking bench for alu_issue_ctrl with a behavioural ALU attached.
module tb_alu_issue_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] instr;
   logic [63:0] rs1_val;
   logic [63:0] rs2_val;
   logic [63:0] alu_a;
   logic [63:0] alu_b;
   logic [3:0]  alu_ctrl;
   logic [63:0] alu_result;
   logic        alu_zero;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_result;
   logic        out_taken;
   logic        out_illegal;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   alu_issue_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .instr       (instr),
      .rs1_val     (rs1_val),
      .rs2_val     (rs2_val),
      .alu_a       (alu_a),
      .alu_b       (alu_b),
      .alu_ctrl    (alu_ctrl),
      .alu_result  (alu_result),
      .alu_zero    (alu_zero),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_result  (out_result),
      .out_taken   (out_taken),
      .out_illegal (out_illegal)
   );

   // Paired ALU
   always_comb begin
      case (alu_ctrl)
         4'b0000: alu_result = alu_a & alu_b;
         4'b0001: alu_result = alu_a | alu_b;
         4'b0010: alu_result = alu_a + alu_b;
         4'b0110: alu_result = alu_a - alu_b;
         4'b0011: alu_result = alu_a ^ alu_b;
         default: alu_result = 64'd0;
      endcase
      alu_zero = (alu_result == 64'd0);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
      else             n_pass++;
   endtask

   task automatic run_op(input string tag, input logic [31:0] i, input logic [63:0] a,
                         input logic [63:0] b, input logic [3:0] e_ctrl, input logic [63:0] e_b,
                         input logic [63:0] e_res, input logic e_taken, input logic e_ill,
                         input int hold);
      logic [63:0] e_a;
      e_a = e_ill ? 64'd0 : a;
      @(negedge clk);
      check({tag, ".in_ready_idle"}, 64'(in_ready), 64'd1);
      instr = i; rs1_val = a; rs2_val = b; in_valid = 1'b1;
      out_ready = (hold == 0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check({tag, ".alu_ctrl"}, 64'(alu_ctrl), 64'(e_ctrl));
      check({tag, ".alu_a"}, alu_a, e_a);
      check({tag, ".alu_b"}, alu_b, e_b);
      check({tag, ".exec_in_ready"}, 64'(in_ready), 64'd0);
      check({tag, ".exec_out_valid"}, 64'(out_valid), 64'd0);
      @(posedge clk); #1;
      check({tag, ".out_valid"}, 64'(out_valid), 64'd1);
      check({tag, ".result"}, out_result, e_res);
      check({tag, ".taken"}, 64'(out_taken), 64'(e_taken));
      check({tag, ".illegal"}, 64'(out_illegal), 64'(e_ill));
      for (int k = 0; k < hold; k++) begin
         @(posedge clk); #1;
         check({tag, ".hold_valid"}, 64'(out_valid), 64'd1);
         check({tag, ".hold_result"}, out_result, e_res);
         check({tag, ".hold_illegal"}, 64'(out_illegal), 64'(e_ill));
         check({tag, ".hold_in_ready"}, 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      check({tag, ".done_valid"}, 64'(out_valid), 64'd0);
      check({tag, ".done_in_ready"}, 64'(in_ready), 64'd1);
   endtask

   localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      instr = 32'd0; rs1_val = 64'd0; rs2_val = 64'd0;
      repeat (2) @(posedge clk);
      #1;
      check("rst.in_ready", 64'(in_ready), 64'd1);
      check("rst.out_valid", 64'(out_valid), 64'd0);
      check("rst.alu_ctrl", 64'(alu_ctrl), 64'd0);
      check("rst.out_result", out_result, 64'd0);
      @(negedge clk); rst = 1'b0;

      run_op("add",   32'h0000_0033, 64'd5, 64'd7, 4'b0010, 64'd7, 64'd12, 1'b0, 1'b0, 0);
      run_op("sub",   32'h4000_0033, 64'd0, 64'd1, 4'b0110, 64'd1, ONES, 1'b0, 1'b0, 0);
      run_op("addi",  32'hFFD0_0013, 64'd10, 64'd99, 4'b0010, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 1'b0, 1'b0, 0);
      run_op("beq",   32'h0000_0063, 64'd42, 64'd42, 4'b0110, 64'd42, 64'd0, 1'b1, 1'b0, 0);
      run_op("bne",   32'h0000_1063, 64'd42, 64'd42, 4'b0110, 64'd42, 64'd0, 1'b0, 1'b0, 0);
      run_op("bne_t", 32'h0000_1063, 64'd1, 64'd2, 4'b0110, 64'd2, ONES, 1'b1, 1'b0, 0);
      run_op("and",   32'h0000_7033, 64'hC, 64'hA, 4'b0000, 64'hA, 64'h8, 1'b0, 1'b0, 0);
      run_op("or",    32'h0000_6033, 64'hC, 64'hA, 4'b0001, 64'hA, 64'hE, 1'b0, 1'b0, 0);
      run_op("store", 32'hFE00_0FA3, 64'd100, 64'd5, 4'b0010, ONES, 64'd99, 1'b0, 1'b0, 0);
      run_op("load",  32'h0080_3003, 64'h1000, 64'd5, 4'b0010, 64'd8, 64'h1008, 1'b0, 1'b0, 0);
      run_op("badop", 32'h0000_007F, 64'd5, 64'd7, 4'b0000, 64'd0, 64'd0, 1'b0, 1'b1, 0);
      run_op("blt",   32'h0000_4063, 64'd1, 64'd2, 4'b0000, 64'd0, 64'd0, 1'b0, 1'b1, 0);
`ifdef ALU_ISSUE_XOR_EN
      run_op("xor_bp", 32'h0000_4033, 64'hF0, 64'hFF, 4'b0011, 64'hFF, 64'h0F, 1'b0, 1'b0, 5);
`else
      run_op("xor_bp", 32'h0000_4033, 64'hF0, 64'hFF, 4'b0000, 64'd0, 64'd0, 1'b0, 1'b1, 5);
`endif

      // Reset in the middle of EXEC drops the transaction
      @(negedge clk);
      instr = 32'h0000_0033; rs1_val = 64'd3; rs2_val = 64'd4; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("mid.exec_ctrl", 64'(alu_ctrl), 64'd2);
      #2 rst = 1'b1;
      #1;
      check("mid.in_ready", 64'(in_ready), 64'd1);
      check("mid.out_valid", 64'(out_valid), 64'd0);
      check("mid.alu_a", alu_a, 64'd0);
      check("mid.alu_b", alu_b, 64'd0);
      check("mid.alu_ctrl", 64'(alu_ctrl), 64'd0);
      check("mid.out_result", out_result, 64'd0);
      check("mid.out_illegal", 64'(out_illegal), 64'd0);
      @(posedge clk); #1;
      check("mid.next_out_valid", 64'(out_valid), 64'd0);
      check("mid.next_in_ready", 64'(in_ready), 64'd1);
      @(negedge clk); rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         check("mid.no_resp", 64'(out_valid), 64'd0);
      end

      run_op("post_rst", 32'h0000_0033, 64'd20, 64'd22, 4'b0010, 64'd22, 64'd42, 1'b0, 1'b0, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
